// File: rtl/ewrapper_io_tx_ser.sv
// eLink TX serialiser in the fast clock domain: one-word hold register, per-lane
// even/odd pair selection for ODDR primitives, training/idle fill and underrun flag.
module ewrapper_io_tx_ser #(
  parameter int unsigned NCH       = 9,
  parameter int unsigned RATIO     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          INVERT    = 1'b0,
  parameter logic [15:0] TRAIN_PAT = 16'h0055
) (
  input  logic                   CLK_IN,
  input  logic                   IO_RESET,
  input  logic [NCH*RATIO-1:0]   DATA_IN,
  input  logic                   DATA_VALID,
  output logic                   DATA_READY,
  input  logic                   TRAIN_REQ,
  input  logic                   UNDERRUN_CLR,
  output logic [NCH-1:0]         DATA_EVEN,
  output logic [NCH-1:0]         DATA_ODD,
  output logic                   FRAME_START,
  output logic                   TRAIN_ACTIVE,
  output logic                   UNDERRUN
);

  localparam int unsigned W  = NCH * RATIO;
  localparam int unsigned P  = RATIO / 2;
  localparam int unsigned PW = (P > 1) ? $clog2(P) : 1;
  localparam int unsigned LW = $clog2(RATIO);
  localparam logic [RATIO-1:0] LANE_PAT = TRAIN_PAT[RATIO-1:0];

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_TRAIN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PW-1:0]    r_phase;
  logic [W-1:0]     r_hold;
  logic             r_hold_valid;
  logic [W-1:0]     r_shift;
  logic [W-1:0]     w_shift_nxt;
  logic [W-1:0]     w_train_word;
  logic             w_boundary;
  logic             w_accept;
  logic             w_consume;
  logic             w_underrun_set;
  logic [LW-1:0]    w_two_p;
  logic [LW-1:0]    w_idx_even;
  logic [LW-1:0]    w_idx_odd;
  logic [RATIO-1:0] w_lane;
  logic [NCH-1:0]   w_even;
  logic [NCH-1:0]   w_odd;

  assign w_boundary   = (r_phase == PW'(P - 1));
  assign w_train_word = {NCH{LANE_PAT}};
  assign DATA_READY   = !IO_RESET && (!r_hold_valid || (w_boundary && !TRAIN_REQ));
  assign w_accept     = DATA_VALID && DATA_READY;

  // Free-running word phase counter
  always_ff @(posedge CLK_IN or posedge IO_RESET) begin
    if (IO_RESET) r_phase <= '0;
    else          r_phase <= w_boundary ? '0 : r_phase + PW'(1);
  end

  // State register and shift register
  always_ff @(posedge CLK_IN or posedge IO_RESET) begin
    if (IO_RESET) begin
      r_state <= S_IDLE;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Boundary load: training beats held data beats idle fill
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_consume      = 1'b0;
    w_underrun_set = 1'b0;
    if (w_boundary) begin
      if (TRAIN_REQ) begin
        w_state_nxt = S_TRAIN;
        w_shift_nxt = w_train_word;
      end else if (r_hold_valid) begin
        w_state_nxt = S_DATA;
        w_shift_nxt = r_hold;
        w_consume   = 1'b1;
      end else begin
        w_state_nxt    = S_IDLE;
        w_shift_nxt    = '0;
        w_underrun_set = (r_state == S_DATA);
      end
    end
  end

  always_ff @(posedge CLK_IN or posedge IO_RESET) begin
    if (IO_RESET) begin
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
    end else if (w_accept) begin
      r_hold       <= DATA_IN;
      r_hold_valid <= 1'b1;
    end else if (w_consume) begin
      r_hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK_IN or posedge IO_RESET) begin
    if (IO_RESET)            UNDERRUN <= 1'b0;
    else if (w_underrun_set) UNDERRUN <= 1'b1;
    else if (UNDERRUN_CLR)   UNDERRUN <= 1'b0;
  end

  // Bit indices of the current pair within a lane
  assign w_two_p    = LW'({r_phase, 1'b0});
  assign w_idx_even = MSB_FIRST ? (LW'(RATIO - 1) - w_two_p) : w_two_p;
  assign w_idx_odd  = MSB_FIRST ? (LW'(RATIO - 2) - w_two_p) : (w_two_p + LW'(1));

  always_comb begin
    w_even = '0;
    w_odd  = '0;
    w_lane = '0;
    for (int c = 0; c < NCH; c++) begin
      w_lane    = r_shift[c*RATIO +: RATIO];
      w_even[c] = w_lane[w_idx_even];
      w_odd[c]  = w_lane[w_idx_odd];
    end
  end

  // Output register; polarity inversion lives here so idle level is {NCH{INVERT}}
  always_ff @(posedge CLK_IN or posedge IO_RESET) begin
    if (IO_RESET) begin
      DATA_EVEN    <= {NCH{INVERT}};
      DATA_ODD     <= {NCH{INVERT}};
      FRAME_START  <= 1'b0;
      TRAIN_ACTIVE <= 1'b0;
    end else begin
      DATA_EVEN    <= w_even ^ {NCH{INVERT}};
      DATA_ODD     <= w_odd ^ {NCH{INVERT}};
      FRAME_START  <= (r_phase == '0);
      TRAIN_ACTIVE <= (r_state == S_TRAIN);
    end
  end

endmodule

// File: tb/tb_ewrapper_io_tx_ser.sv
// Bench for ewrapper_io_tx_ser: default 9x8 instance plus a 1-lane ratio-2 inverted
// instance, checked against transaction-level reference models.
module tb_ewrapper_io_tx_ser;

  localparam logic [71:0] TRAIN_WORD = {9{8'h55}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [71:0] a_din;
  logic        a_valid, a_ready, a_train, a_clr;
  logic [8:0]  a_even, a_odd;
  logic        a_fs, a_ta, a_ur;

  logic [1:0]  b_din;
  logic        b_valid, b_ready, b_train, b_clr;
  logic [0:0]  b_even, b_odd;
  logic        b_fs, b_ta, b_ur;

  ewrapper_io_tx_ser u_dut_a (
    .CLK_IN(clk), .IO_RESET(rst), .DATA_IN(a_din), .DATA_VALID(a_valid),
    .DATA_READY(a_ready), .TRAIN_REQ(a_train), .UNDERRUN_CLR(a_clr),
    .DATA_EVEN(a_even), .DATA_ODD(a_odd), .FRAME_START(a_fs),
    .TRAIN_ACTIVE(a_ta), .UNDERRUN(a_ur)
  );

  ewrapper_io_tx_ser #(.NCH(1), .RATIO(2), .MSB_FIRST(1'b0), .INVERT(1'b1)) u_dut_b (
    .CLK_IN(clk), .IO_RESET(rst), .DATA_IN(b_din), .DATA_VALID(b_valid),
    .DATA_READY(b_ready), .TRAIN_REQ(b_train), .UNDERRUN_CLR(b_clr),
    .DATA_EVEN(b_even), .DATA_ODD(b_odd), .FRAME_START(b_fs),
    .TRAIN_ACTIVE(b_ta), .UNDERRUN(b_ur)
  );

  int checks = 0;
  int errors = 0;
  bit chkb   = 1'b0;

  // Reference model for instance A: words of 9 lanes x 8 bits, 4 pairs per word
  int          m_phase;
  bit          m_hold_v, m_ur, m_acc;
  logic [71:0] m_hold, m_word;
  int          m_kind;          // 0 idle, 1 data, 2 training
  logic [8:0]  e_even, e_odd;
  bit          e_fs, e_ta;

  // Reference model for instance B: accepted symbol appears two edges later
  int b_hold, b_s1;
  bit b_e_even, b_e_odd, b_e_fs;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] pair_bits(input logic [71:0] w, input int p, input int odd);
    logic [8:0]  r;
    logic [71:0] t;
    for (int c = 0; c < 9; c++) begin
      t    = w >> (c*8 + 7 - 2*p - odd);
      r[c] = t[0];
    end
    return r;
  endfunction

  function automatic bit a_ready_exp();
    return !m_hold_v || (m_phase == 3 && !a_train);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_hold_v = 0; m_ur = 0; m_acc = 0; m_hold = '0; m_word = '0; m_kind = 0;
    e_even = '0; e_odd = '0; e_fs = 0; e_ta = 0;
    b_hold = -1; b_s1 = -1; b_e_even = 1; b_e_odd = 1; b_e_fs = 0;
  endtask

  task automatic model_a_edge();
    bit bnd, rdy, set;
    bnd   = (m_phase == 3);
    rdy   = !m_hold_v || (bnd && !a_train);
    set   = 0;
    m_acc = a_valid && rdy;
    e_even = pair_bits(m_word, m_phase, 0);
    e_odd  = pair_bits(m_word, m_phase, 1);
    e_fs   = (m_phase == 0);
    e_ta   = (m_kind == 2);
    if (bnd) begin
      if (a_train) begin
        m_word = TRAIN_WORD; m_kind = 2;
      end else if (m_hold_v) begin
        m_word = m_hold; m_kind = 1; m_hold_v = 0;
      end else begin
        set = (m_kind == 1); m_word = '0; m_kind = 0;
      end
    end
    if (set) m_ur = 1;
    else if (a_clr) m_ur = 0;
    if (m_acc) begin m_hold = a_din; m_hold_v = 1; end
    m_phase = bnd ? 0 : m_phase + 1;
  endtask

  task automatic model_b_edge();
    if (b_s1 < 0) begin
      b_e_even = 1; b_e_odd = 1;
    end else begin
      b_e_even = ((b_s1 & 1) == 0);
      b_e_odd  = ((b_s1 & 2) == 0);
    end
    b_e_fs = 1;
    b_s1   = b_hold;
    b_hold = b_valid ? int'(b_din) : -1;
  endtask

  // One clock: check ready before the edge, outputs just after it
  task automatic step();
    #1;
    chk("ready", 72'(a_ready), 72'(a_ready_exp()));
    if (chkb) chk("b_ready", 72'(b_ready), 72'(1));
    @(posedge clk);
    model_a_edge();
    model_b_edge();
    #1;
    chk("even", 72'(a_even), 72'(e_even));
    chk("odd", 72'(a_odd), 72'(e_odd));
    chk("frame_start", 72'(a_fs), 72'(e_fs));
    chk("train_active", 72'(a_ta), 72'(e_ta));
    chk("underrun", 72'(a_ur), 72'(m_ur));
    if (chkb) begin
      chk("b_even", 72'(b_even), 72'(b_e_even));
      chk("b_odd", 72'(b_odd), 72'(b_e_odd));
      chk("b_frame_start", 72'(b_fs), 72'(b_e_fs));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  t1_ev, t1_od;
    logic [71:0] words [3];
    int          k, ta_cnt;

    rst = 1; a_din = '0; a_valid = 0; a_train = 0; a_clr = 0;
    b_din = '0; b_valid = 0; b_train = 0; b_clr = 0;
    model_reset();
    #11;
    chk("rst_even", 72'(a_even), 72'(0));
    chk("rst_fs", 72'(a_fs), 72'(0));
    chk("rst_ta", 72'(a_ta), 72'(0));
    chk("rst_ur", 72'(a_ur), 72'(0));
    chk("rst_b_even", 72'(b_even), 72'(1));
    rst = 0;

    // Single 8'hA5 word on lane 0, valid pulsed in the first cycle
    t1_ev = 4'b0011; t1_od = 4'b1100;
    a_din = 72'h0A5; a_valid = 1;
    step();
    a_valid = 0; a_din = '0;
    for (int i = 2; i <= 9; i++) begin
      step();
      if (i >= 5 && i <= 8) begin
        chk("t1_even0", 72'(a_even[0]), 72'(t1_ev[i-5]));
        chk("t1_odd0", 72'(a_odd[0]), 72'(t1_od[i-5]));
        chk("t1_other", 72'({a_even[8:1], a_odd[8:1]}), 72'(0));
        chk("t1_ta", 72'(a_ta), 72'(0));
      end
      if (i == 5) chk("t1_fs", 72'(a_fs), 72'(1));
    end

    // Three back-to-back words with valid held high
    a_clr = 1; step(); a_clr = 0;
    words[0] = {9{8'h01}}; words[1] = {9{8'h02}}; words[2] = {9{8'h03}};
    k = 0;
    a_valid = 1; a_din = words[0];
    for (int i = 0; i < 40 && k < 3; i++) begin
      step();
      if (m_acc) begin
        k++;
        if (k < 3) a_din = words[k];
      end
    end
    chk("t2_accepted", 72'(k), 72'(3));
    a_valid = 0; a_din = '0;
    for (int i = 0; i < 12; i++) step();
    chk("t2_ur_set", 72'(a_ur), 72'(1));
    a_clr = 1; step(); a_clr = 0;
    chk("t2_ur_clr", 72'(a_ur), 72'(0));

    // Training across two boundaries while a word is held
    a_din = {$urandom, $urandom, $urandom}; a_valid = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (m_acc) break;
    end
    a_valid = 0; a_train = 1; ta_cnt = 0;
    for (int i = 0; i < 8; i++) begin step(); ta_cnt += int'(a_ta); end
    a_train = 0;
    chk("t3_ur", 72'(a_ur), 72'(0));
    for (int i = 0; i < 14; i++) begin step(); ta_cnt += int'(a_ta); end
    chk("t3_ta_cycles", 72'(ta_cnt), 72'(8));

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      a_valid = ($urandom_range(0, 9) < 7);
      a_din   = 72'({$urandom, $urandom, $urandom});
      if ($urandom_range(0, 15) == 0) a_train = !a_train;
      a_clr   = ($urandom_range(0, 9) == 0);
      step();
    end
    a_valid = 0; a_train = 0; a_clr = 0;

    // Reset in the middle of a data word
    a_valid = 1;
    for (int i = 0; i < 40; i++) begin
      a_din = 72'({$urandom, $urandom, $urandom});
      step();
      if (m_kind == 1 && m_phase == 2) break;
    end
    a_valid = 0;
    #2 rst = 1;
    #1;
    chk("t6_even", 72'(a_even), 72'(0));
    chk("t6_odd", 72'(a_odd), 72'(0));
    chk("t6_fs", 72'(a_fs), 72'(0));
    chk("t6_ta", 72'(a_ta), 72'(0));
    chk("t6_ur", 72'(a_ur), 72'(0));
    @(posedge clk); #1;
    rst = 0;
    model_reset();

    // Idle after reset: frame every 4 cycles, first boundary at edge 4
    for (int i = 1; i <= 12; i++) begin
      step();
      chk("t4_fs", 72'(a_fs), 72'((i % 4) == 1));
      chk("t4_even", 72'({a_even, a_odd}), 72'(0));
    end
    chk("t4_ur", 72'(a_ur), 72'(0));

    // One-lane ratio-2 inverted instance: one word per cycle
    chkb = 1;
    b_din = 2'b01; b_valid = 1; step();
    b_din = 2'b10; step();
    b_valid = 0; step();
    chk("t5_pair0", 72'({b_even, b_odd}), 72'(2'b01));
    step();
    chk("t5_pair1", 72'({b_even, b_odd}), 72'(2'b10));
    for (int i = 0; i < 40; i++) begin
      b_valid = ($urandom_range(0, 3) != 0);
      b_din   = 2'($urandom_range(0, 3));
      step();
    end
    b_valid = 0;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ewrapper_io_tx_ser.md
Name: ewrapper_io_tx_ser

Overview:
Parametrised eLink TX serialiser that runs entirely in the fast transmit clock domain. It accepts parallel words through a valid/ready handshake instead of sampling a slow-clock edge, and splits each word into per-channel even/odd bit pairs that drive DDR output primitives. Compared with the fixed 9-channel/8:1 serialiser, it adds configurable channel count, ratio, bit order and inversion, a training-pattern mode, an idle fill and underrun reporting. It sits between the TX framing logic and the ODDR/OBUFDS pin stage.

Parameters:
NCH, 9, number of serial lanes (1..16)
RATIO, 8, bits per lane per word; even, 2..16; P = RATIO/2 clock cycles per word
MSB_FIRST, 1, 1: lane bit RATIO-1 transmitted first; 0: bit 0 first
INVERT, 0, 1: invert every DATA_EVEN/DATA_ODD bit at the output register (E64 polarity)
TRAIN_PAT, 16'h0055, training pattern; low RATIO bits used, same pattern on every lane

Ports:
CLK_IN  in  1  fast transmit clock (same clock as the ODDR stage)
IO_RESET  in  1  asynchronous reset, active-high
DATA_IN  in  NCH*RATIO  word; lane c = DATA_IN[c*RATIO +: RATIO]
DATA_VALID  in  1  DATA_IN valid
DATA_READY  out  1  block can accept DATA_IN this cycle
TRAIN_REQ  in  1  level; send the training pattern instead of data while high
UNDERRUN_CLR  in  1  clears UNDERRUN
DATA_EVEN  out  NCH  ODDR D1 per lane (first bit of the pair)
DATA_ODD  out  NCH  ODDR D2 per lane (second bit of the pair)
FRAME_START  out  1  high on the first pair of every word, including data, training and idle words
TRAIN_ACTIVE  out  1  high for all P cycles of a training word, aligned with DATA_EVEN/DATA_ODD
UNDERRUN  out  1  sticky; a data stream ran dry

Behaviour:
- Reset (async assert, sync release): all outputs go to the idle level.
  - DATA_EVEN = DATA_ODD = {NCH{INVERT}}.
  - FRAME_START, TRAIN_ACTIVE and UNDERRUN = 0.
  - Phase counter = 0, hold register empty, state = IDLE.
  - DATA_READY = 1 while reset is deasserted and the hold register is empty.
- Phase counter:
  - Counts 0..P-1 and wraps; it runs freely from reset release.
  - "Boundary" = a cycle with phase == P-1.
  - For P = 1, every cycle is a boundary.
- Hold register (one word deep):
  - DATA_READY = !hold_valid | (boundary & !TRAIN_REQ). This is combinational.
  - Accept = DATA_VALID & DATA_READY. On accept, hold loads DATA_IN and hold_valid = 1.
  - A word consumed at a boundary clears hold_valid unless a new word is accepted in the same cycle.
- Boundary load into the shift register, in priority order:
  1. TRAIN_REQ = 1: load TRAIN_PAT on every lane; hold is untouched; state = TRAIN.
  2. hold_valid = 1: load the hold word; state = DATA.
  3. Otherwise: load all-zero (idle); state = IDLE. If the previous state was DATA, set UNDERRUN.
- State transitions: IDLE, DATA and TRAIN change only at boundaries, per the table above.
- UNDERRUN: sticky. Set has priority over UNDERRUN_CLR in the same cycle.
- Pair selection at phase p:
  - MSB_FIRST = 1: even = bit RATIO-1-2p, odd = bit RATIO-2-2p.
  - MSB_FIRST = 0: even = bit 2p, odd = bit 2p+1.
- Output register: DATA_EVEN, DATA_ODD, FRAME_START and TRAIN_ACTIVE are registered once after the shift register, with INVERT applied there.
- Latency: pair 0 of a word loaded at boundary edge B appears on the outputs after edge B+1.
  - Minimum latency from the accept edge to pair 0 is 2 cycles.
  - A word accepted into an empty hold at a boundary edge waits for the next boundary.
- Throughput: one word per P cycles with no gaps while DATA_VALID stays high.
- TRAIN_REQ is sampled only at boundaries; a training word is never truncated.
- Reset mid-word: the word is discarded, outputs go to idle immediately, and the hold contents are lost.

Test Plan:
1. Defaults; reset; lane 0 = 8'hA5, other lanes 0, VALID pulsed in cycle 1 → DATA_READY = 1 in the accept cycle. First FRAME_START after 2..5 cycles. Lane 0 even sequence 1,1,0,0; odd sequence 0,0,1,1; other lanes 0; TRAIN_ACTIVE = 0.
2. Three words 8'h01/8'h02/8'h03 on every lane, VALID held high → 12 contiguous output cycles. FRAME_START every 4th cycle. DATA_READY low between boundaries. UNDERRUN set after the third word, then cleared by UNDERRUN_CLR.
3. TRAIN_REQ high across two boundaries while a word is held → two training words (even 0,0,0,0; odd 1,1,1,1 on all 9 lanes, TRAIN_ACTIVE = 1 for 8 cycles). The held word follows immediately. No UNDERRUN.
4. Idle, no data → outputs 0 and FRAME_START every 4 cycles. UNDERRUN stays 0, since the block never entered DATA.
5. NCH = 1, RATIO = 2, MSB_FIRST = 0, INVERT = 1; stream 2'b01, 2'b10 → DATA_READY constantly 1 and one word per cycle. Outputs (even, odd) = (0,1) then (1,0).
6. IO_RESET asserted at phase 2 of a data word → outputs are idle in the same cycle, with no clock edge required. After release the phase counter restarts at 0 and the first boundary is at edge 4.
